xbar_rr_scheduler: RTL and testbench

- Per-output round-robin scheduler for the NUM_INPUTS x NUM_OUTPUTS crossbar datapath.
- Collects each input's valid/destination request and issues a registered one-hot grant per output.
- Holds the grant for a multi-beat burst until the last beat, the hold limit, or the requester abandoning.
- Drives the crossbar's per-output input_grant matrix and returns per-input ready to the sources.

---
 rtl/xbar_sched_pkg.sv | 11 +
 rtl/xbar_rr_pick.sv | 34 +++
 rtl/xbar_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_xbar_rr_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_sched_pkg.sv
// Shared types and width helper for the crossbar round-robin scheduler.
package xbar_sched_pkg;

    typedef enum logic {StIdle, StLocked} sched_state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// Rotate-priority picker: first asserted request at or after i_ptr, wrapping modulo NUM_REQ.
module xbar_rr_pick
    import xbar_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, i_ptr} + SUM_W'(k);
            if (w_cand >= SUM_W'(NUM_REQ)) begin
                w_cand = w_cand - SUM_W'(NUM_REQ);
            end
            if (!o_found && i_req[w_cand[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/xbar_rr_scheduler.sv
// Per-output round-robin burst scheduler for the crossbar.
// Optional XBAR_SCHED_STATS_EN adds per-output completed-burst counters (grant_count).
module xbar_rr_scheduler
    import xbar_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned NUM_OUTPUTS = 8,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_INPUTS-1:0]             req_valid,
    input  logic [NUM_INPUTS*idx_width(NUM_OUTPUTS)-1:0] req_dest,
    input  logic [NUM_INPUTS-1:0]             req_last,
    input  logic [NUM_OUTPUTS-1:0]            out_ready,
    output logic [NUM_OUTPUTS*NUM_INPUTS-1:0] grant,
    output logic [NUM_INPUTS-1:0]             req_ready,
    output logic                              busy
`ifdef XBAR_SCHED_STATS_EN
    ,
    output logic [NUM_OUTPUTS*16-1:0]         grant_count
`endif
);

    localparam int unsigned SEL_W  = idx_width(NUM_OUTPUTS);
    localparam int unsigned IDX_W  = idx_width(NUM_INPUTS);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] w_xfer_mat;
    logic [NUM_OUTPUTS-1:0]                 w_lock_d;
    logic                                   r_busy;

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        logic [NUM_INPUTS-1:0] w_req;
        logic                  w_found;
        logic [IDX_W-1:0]      w_pick;
        sched_state_e          r_state, w_state_d;
        logic [IDX_W-1:0]      r_ptr, w_ptr_d, r_owner, w_owner_d, w_next_ptr;
        logic [HOLD_W-1:0]     r_hold, w_hold_d, w_hold_inc;
        logic [NUM_INPUTS-1:0] r_grant, w_grant_d;
        logic                  w_own_req, w_xfer, w_done;

        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
            assign w_req[i] = req_valid[i] && (req_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
        end

        xbar_rr_pick #(
            .NUM_REQ (NUM_INPUTS),
            .IDX_W   (IDX_W)
        ) u_pick (
            .i_req   (w_req),
            .i_ptr   (r_ptr),
            .o_found (w_found),
            .o_idx   (w_pick)
        );

        // Owner still asking for this output; otherwise the burst is abandoned.
        assign w_own_req  = w_req[r_owner];
        assign w_xfer     = (r_state == StLocked) && w_own_req && out_ready[o];
        assign w_hold_inc = (r_hold == HOLD_W'(MAX_HOLD)) ? r_hold : r_hold + HOLD_W'(1);
        assign w_done     = w_xfer && (req_last[r_owner] || (w_hold_inc == HOLD_W'(MAX_HOLD)));
        assign w_next_ptr = (r_owner == IDX_W'(NUM_INPUTS - 1)) ? '0 : r_owner + IDX_W'(1);

        always_comb begin
            w_state_d = r_state;
            w_ptr_d   = r_ptr;
            w_owner_d = r_owner;
            w_hold_d  = r_hold;
            w_grant_d = r_grant;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        w_state_d = StLocked;
                        w_owner_d = w_pick;
                        w_hold_d  = '0;
                        w_grant_d = NUM_INPUTS'(1) << w_pick;
                    end
                end
                StLocked: begin
                    if (w_xfer) begin
                        w_hold_d = w_hold_inc;
                    end
                    if (!w_own_req || w_done) begin
                        w_state_d = StIdle;
                        w_grant_d = '0;
                        w_ptr_d   = w_next_ptr;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_grant_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= StIdle;
                r_ptr   <= '0;
                r_owner <= '0;
                r_hold  <= '0;
                r_grant <= '0;
            end else begin
                r_state <= w_state_d;
                r_ptr   <= w_ptr_d;
                r_owner <= w_owner_d;
                r_hold  <= w_hold_d;
                r_grant <= w_grant_d;
            end
        end

        assign grant[o*NUM_INPUTS +: NUM_INPUTS] = r_grant;
        assign w_xfer_mat[o] = r_grant & {NUM_INPUTS{w_xfer}};
        assign w_lock_d[o]   = (w_state_d == StLocked);

`ifdef XBAR_SCHED_STATS_EN
        logic [15:0] r_count;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_count <= '0;
            end else if (w_done && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
        end

        assign grant_count[o*16 +: 16] = r_count;
`endif
    end

    // An input has a single destination, so at most one output row can be set per column.
    always_comb begin
        req_ready = '0;
        for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
            req_ready = req_ready | w_xfer_mat[o];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_lock_d;
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Directed self-checking bench for xbar_rr_scheduler (8x8, MAX_HOLD=16).
module tb_xbar_rr_scheduler;

    localparam int unsigned NI = 8;
    localparam int unsigned NO = 8;
    localparam int unsigned MH = 16;
    localparam int unsigned SW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     req_valid;
    logic [NI*SW-1:0]  req_dest;
    logic [NI-1:0]     req_last;
    logic [NO-1:0]     out_ready;
    logic [NO*NI-1:0]  grant;
    logic [NI-1:0]     req_ready;
    logic              busy;
`ifdef XBAR_SCHED_STATS_EN
    logic [NO*16-1:0]  grant_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xbar_rr_scheduler #(
        .NUM_INPUTS  (NI),
        .NUM_OUTPUTS (NO),
        .MAX_HOLD    (MH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_last    (req_last),
        .out_ready   (out_ready),
        .grant       (grant),
        .req_ready   (req_ready),
`ifdef XBAR_SCHED_STATS_EN
        .grant_count (grant_count),
`endif
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NI-1:0] row(input int o);
        return grant[o*NI +: NI];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int d, input logic l);
        req_valid[i]            = v;
        req_dest[i*SW +: SW]    = SW'(d);
        req_last[i]             = l;
    endtask

    logic [7:0] exp_rr   [8] = '{8'h02, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00};
    logic       b_ordy   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       b_last   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_r1   [5] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01};
    logic [7:0] exp_r5   [5] = '{8'h04, 8'h00, 8'h04, 8'h00, 8'h04};
    logic [7:0] exp_rdy6 [5] = '{8'h05, 8'h00, 8'h84, 8'h00, 8'h05};

    initial begin
        // Reset held with every input requesting.
        rst       = 1'b1;
        req_valid = '1;
        req_dest  = '0;
        req_last  = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 64'h0);
        check("rst_ready", req_ready, 8'h00);
        check("rst_busy", busy, 1'b0);
        req_valid = '0;
        rst       = 1'b0;
        tick();
        check("idle_grant", grant, 64'h0);

        // First grant one cycle after a sampled request.
        set_req(0, 1'b1, 0, 1'b1);
        #1;
        check("pre_grant", row(0), 8'h00);
        check("pre_ready", req_ready, 8'h00);
        tick();
        check("lat_grant", row(0), 8'h01);
        check("lat_ready", req_ready, 8'h01);
        check("lat_busy", busy, 1'b1);
        tick();
        check("lat_release", row(0), 8'h00);
        check("lat_busy_clr", busy, 1'b0);
        set_req(0, 1'b0, 0, 1'b0);

        // Inputs 1,3,5 single beats to output 2.
        set_req(1, 1'b1, 2, 1'b1);
        set_req(3, 1'b1, 2, 1'b1);
        set_req(5, 1'b1, 2, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr_row2_%0d", k), row(2), exp_rr[k]);
            check($sformatf("rr_ready_%0d", k), req_ready, exp_rr[k]);
        end
        set_req(1, 1'b0, 0, 1'b0);
        set_req(3, 1'b0, 0, 1'b0);
        set_req(5, 1'b0, 0, 1'b0);
        tick();

        // Input 4, five beats to output 0, stalled two cycles.
        set_req(4, 1'b1, 0, 1'b0);
        tick();
        check("burst_grant", row(0), 8'h10);
        for (int k = 0; k < 7; k++) begin
            out_ready[0] = b_ordy[k];
            req_last[4]  = b_last[k];
            #1;
            check($sformatf("burst_hold_%0d", k), row(0), 8'h10);
            check($sformatf("burst_ready_%0d", k), req_ready, b_ordy[k] ? 8'h10 : 8'h00);
            tick();
        end
        check("burst_release", row(0), 8'h00);
        check("burst_busy", busy, 1'b0);
        set_req(4, 1'b0, 0, 1'b0);
        out_ready = '1;
        tick();

        // Forced release after MAX_HOLD beats with a competing requester.
        set_req(0, 1'b1, 7, 1'b0);
        set_req(6, 1'b1, 7, 1'b1);
        tick();
        check("hold_grant", row(7), 8'h01);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("hold_row_%0d", k), row(7), 8'h01);
            check($sformatf("hold_ready_%0d", k), req_ready, 8'h01);
            tick();
        end
        check("hold_forced", row(7), 8'h00);
        check("hold_busy", busy, 1'b0);
        tick();
        check("hold_next", row(7), 8'h40);
        check("hold_next_rdy", req_ready, 8'h40);
        tick();
        check("hold_next_rel", row(7), 8'h00);
        set_req(6, 1'b0, 0, 1'b0);
        tick();
        check("hold_regrant", row(7), 8'h01);
        for (int k = 0; k < 4; k++) begin
            req_last[0] = (k == 3);
            #1;
            check($sformatf("tail_ready_%0d", k), req_ready, 8'h01);
            tick();
        end
        check("tail_release", row(7), 8'h00);
        set_req(0, 1'b0, 0, 1'b0);
        tick();

        // Abandon on output 3; pointer must land on 3.
        set_req(2, 1'b1, 3, 1'b0);
        tick();
        check("ab_grant", row(3), 8'h04);
        set_req(2, 1'b0, 3, 1'b0);
        #1;
        check("ab_ready", req_ready, 8'h00);
        tick();
        check("ab_release", row(3), 8'h00);
`ifdef XBAR_SCHED_STATS_EN
        check("ab_count", grant_count[3*16 +: 16], 16'd0);
`endif
        set_req(0, 1'b1, 3, 1'b1);
        set_req(2, 1'b1, 3, 1'b1);
        set_req(3, 1'b1, 3, 1'b1);
        tick();
        check("ab_ptr", row(3), 8'h08);
        tick();
        check("ab_ptr_rel", row(3), 8'h00);
        set_req(0, 1'b0, 0, 1'b0);
        set_req(2, 1'b0, 0, 1'b0);
        set_req(3, 1'b0, 0, 1'b0);
        tick();

        // Concurrent outputs 1 and 5, with ptr[1] wrapping past input 7.
        set_req(0, 1'b1, 1, 1'b1);
        set_req(7, 1'b1, 1, 1'b1);
        set_req(2, 1'b1, 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("cc_row1_%0d", k), row(1), exp_r1[k]);
            check($sformatf("cc_row5_%0d", k), row(5), exp_r5[k]);
            check($sformatf("cc_ready_%0d", k), req_ready, exp_rdy6[k]);
        end
        set_req(0, 1'b0, 0, 1'b0);
        set_req(7, 1'b0, 0, 1'b0);
        set_req(2, 1'b0, 0, 1'b0);
        repeat (2) tick();

        // Asynchronous reset in the middle of a burst.
        set_req(1, 1'b1, 4, 1'b0);
        tick();
        check("mid_grant", row(4), 8'h02);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_grant", grant, 64'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", req_ready, 8'h00);
        set_req(1, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_grant", grant, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
